serial_frame_rx: RTL and testbench

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

---
 rtl/serial_frame_rx.sv | 144 ++++++++++++++
 tb/tb_serial_frame_rx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, LSB-first data, optional parity bit, stop bit.
// Bits are taken on sample_en strobes; a frame stalled for TIMEOUT idle cycles is aborted.
module serial_frame_rx #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int ODD_PARITY = 1,
    parameter int TIMEOUT    = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_data_in,
    input  logic              sample_en,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_valid,
    output logic              frame_error,
    output logic [1:0]        error_code,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int TO_W  = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_PARITY  = 2'b01;
    localparam logic [1:0] ERR_STOP    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              parity_bit;
    logic              parity_ok;
    logic              frame_good;
    logic              frame_bad;
    logic              timeout_fire;
    logic [1:0]        bad_code;

    assign parity_ok = (ODD_PARITY != 0) ? (^{shift_reg, parity_bit}) : ~(^{shift_reg, parity_bit});
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A parity failure outranks a bad stop bit when both occur in one frame.
    always_comb begin
        state_next   = state;
        frame_good   = 1'b0;
        frame_bad    = 1'b0;
        timeout_fire = 1'b0;
        bad_code     = ERR_STOP;
        case (state)
            IDLE: begin
                if (sample_en && !serial_data_in) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (sample_en && bit_cnt == LAST_BIT) begin
                    state_next = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (sample_en) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (sample_en) begin
                    state_next = IDLE;
                    if (PARITY_EN != 0 && !parity_ok) begin
                        frame_bad = 1'b1;
                        bad_code  = ERR_PARITY;
                    end else if (!serial_data_in) begin
                        frame_bad = 1'b1;
                    end else begin
                        frame_good = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (state != IDLE && !sample_en && to_cnt == TO_LAST) begin
            state_next   = IDLE;
            timeout_fire = 1'b1;
        end
    end

    // The timeout counter only runs across gaps inside a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt     <= '0;
            to_cnt      <= '0;
            shift_reg   <= '0;
            parity_bit  <= 1'b0;
            data_out    <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            error_code  <= ERR_NONE;
        end else begin
            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (state == DATA && sample_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (state == DATA && sample_en) begin
                shift_reg[bit_cnt] <= serial_data_in;
            end

            if (state == PARITY && sample_en) begin
                parity_bit <= serial_data_in;
            end

            if (sample_en || state_next == IDLE) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end

            frame_valid <= frame_good;
            frame_error <= frame_bad | timeout_fire;

            if (frame_good) begin
                data_out   <= shift_reg;
                error_code <= ERR_NONE;
            end else if (frame_bad) begin
                error_code <= bad_code;
            end else if (timeout_fire) begin
                error_code <= ERR_TIMEOUT;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: an 8-bit odd-parity receiver with a short
// timeout, plus a 7-bit receiver without parity.
module tb_serial_frame_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       sd_a, se_a, sd_b, se_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       fv_a, fe_a, busy_a, fv_b, fe_b, busy_b;
    logic [1:0] code_a, code_b;

    int assertCount = 0;
    int failCount   = 0;

    serial_frame_rx #(.TIMEOUT(16)) dut_a (
        .clk(clk), .reset(reset), .serial_data_in(sd_a), .sample_en(se_a),
        .data_out(data_a), .frame_valid(fv_a), .frame_error(fe_a),
        .error_code(code_a), .busy(busy_a)
    );

    serial_frame_rx #(.DATA_W(7), .PARITY_EN(0)) dut_b (
        .clk(clk), .reset(reset), .serial_data_in(sd_b), .sample_en(se_b),
        .data_out(data_b), .frame_valid(fv_b), .frame_error(fe_b),
        .error_code(code_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Sends bits[0] first, one bit per cycle, driving inputs just after each negedge.
    task automatic applyStimulus(input logic [15:0] bits, input int n, input bit keep_en, input bit to_b);
        for (int i = 0; i < n; i++) begin
            if (to_b) begin
                sd_b = bits[i];
                se_b = 1'b1;
            end else begin
                sd_a = bits[i];
                se_a = 1'b1;
            end
            @(negedge clk);
        end
        if (!keep_en) begin
            if (to_b) se_b = 1'b0;
            else      se_a = 1'b0;
        end
    endtask

    function automatic logic [15:0] makeFrame(input logic [7:0] d, input logic p, input logic s);
        logic [15:0] f;
        f      = '0;
        f[8:1] = d;
        f[9]   = p;
        f[10]  = s;
        return f;
    endfunction

    task automatic expectGood(input string tag, input logic [7:0] d);
        checkOutput({tag, "_valid"}, fv_a, 1);
        checkOutput({tag, "_error"}, fe_a, 0);
        checkOutput({tag, "_data"}, data_a, d);
        checkOutput({tag, "_code"}, code_a, 2'b00);
        checkOutput({tag, "_busy"}, busy_a, 0);
        @(negedge clk);
        checkOutput({tag, "_valid_len"}, fv_a, 0);
    endtask

    task automatic expectBad(input string tag, input logic [1:0] code, input logic [7:0] d);
        checkOutput({tag, "_error"}, fe_a, 1);
        checkOutput({tag, "_valid"}, fv_a, 0);
        checkOutput({tag, "_code"}, code_a, code);
        checkOutput({tag, "_data"}, data_a, d);
        checkOutput({tag, "_busy"}, busy_a, 0);
        @(negedge clk);
        checkOutput({tag, "_error_len"}, fe_a, 0);
        checkOutput({tag, "_code_hold"}, code_a, code);
    endtask

    initial begin
        reset = 1'b1;
        sd_a  = 1'b1;
        se_a  = 1'b0;
        sd_b  = 1'b1;
        se_b  = 1'b0;
        #2;
        checkOutput("rst_data", data_a, 8'h00);
        checkOutput("rst_valid", fv_a, 0);
        checkOutput("rst_error", fe_a, 0);
        checkOutput("rst_code", code_a, 2'b00);
        checkOutput("rst_busy", busy_a, 0);
        checkOutput("rst_data_b", data_b, 7'h00);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Idle-level samples must not start a frame.
        applyStimulus(16'hFFFF, 3, 1'b0, 1'b0);
        checkOutput("idle_busy", busy_a, 0);
        checkOutput("idle_valid", fv_a, 0);
        checkOutput("idle_error", fe_a, 0);

        // Line order 0,1,0,1,0,0,1,0,1,1,1: data bits give 0xA5, parity 1 makes five ones.
        applyStimulus(16'h074A, 11, 1'b0, 1'b0);
        expectGood("lit", 8'hA5);

        applyStimulus(makeFrame(8'h4A, 1'b0, 1'b1), 11, 1'b0, 1'b0);
        expectGood("d4a", 8'h4A);

        applyStimulus(makeFrame(8'h4A, 1'b1, 1'b1), 11, 1'b0, 1'b0);
        expectBad("par", 2'b01, 8'h4A);

        // Bad stop bit followed immediately by a good frame with no gap.
        applyStimulus(makeFrame(8'h3C, 1'b1, 1'b0), 11, 1'b1, 1'b0);
        checkOutput("b2b1_error", fe_a, 1);
        checkOutput("b2b1_valid", fv_a, 0);
        checkOutput("b2b1_code", code_a, 2'b10);
        checkOutput("b2b1_data", data_a, 8'h4A);
        applyStimulus(makeFrame(8'h3C, 1'b1, 1'b1), 11, 1'b0, 1'b0);
        expectGood("b2b2", 8'h3C);

        applyStimulus(makeFrame(8'h3C, 1'b0, 1'b0), 11, 1'b0, 1'b0);
        expectBad("both", 2'b01, 8'h3C);

        // Start plus three data bits, then a 16-cycle gap aborts the frame.
        applyStimulus(16'h0002, 4, 1'b0, 1'b0);
        repeat (15) @(negedge clk);
        checkOutput("to15_busy", busy_a, 1);
        checkOutput("to15_error", fe_a, 0);
        @(negedge clk);
        checkOutput("to_error", fe_a, 1);
        checkOutput("to_code", code_a, 2'b11);
        checkOutput("to_busy", busy_a, 0);
        checkOutput("to_data", data_a, 8'h3C);
        @(negedge clk);
        checkOutput("to_error_len", fe_a, 0);

        // Same gap, but a sample lands on the 16th cycle and the frame survives.
        applyStimulus(16'h0002, 4, 1'b0, 1'b0);
        repeat (15) @(negedge clk);
        applyStimulus(16'h0000, 1, 1'b1, 1'b0);
        checkOutput("late_error", fe_a, 0);
        checkOutput("late_busy", busy_a, 1);
        checkOutput("late_code_hold", code_a, 2'b11);
        applyStimulus(16'h0038, 6, 1'b0, 1'b0);
        expectGood("late", 8'h81);

        // Reset asserted between clock edges part-way through a frame.
        applyStimulus(makeFrame(8'hFF, 1'b1, 1'b1), 5, 1'b0, 1'b0);
        checkOutput("pre_rst_busy", busy_a, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("mid_rst_data", data_a, 8'h00);
        checkOutput("mid_rst_busy", busy_a, 0);
        checkOutput("mid_rst_code", code_a, 2'b00);
        checkOutput("mid_rst_valid", fv_a, 0);
        checkOutput("mid_rst_error", fe_a, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("post_rst_valid", fv_a, 0);
            checkOutput("post_rst_error", fe_a, 0);
        end
        applyStimulus(makeFrame(8'h4A, 1'b0, 1'b1), 11, 1'b0, 1'b0);
        expectGood("post_rst", 8'h4A);

        // 7-bit receiver without parity: idle ones, then 0x55 in nine samples.
        applyStimulus(16'h0007, 3, 1'b0, 1'b1);
        checkOutput("b_idle_busy", busy_b, 0);
        applyStimulus(16'h01AA, 9, 1'b0, 1'b1);
        checkOutput("b_valid", fv_b, 1);
        checkOutput("b_error", fe_b, 0);
        checkOutput("b_data", data_b, 7'h55);
        checkOutput("b_code", code_b, 2'b00);
        @(negedge clk);
        checkOutput("b_valid_len", fv_b, 0);
        applyStimulus(16'h0054, 9, 1'b0, 1'b1);
        checkOutput("b_stop_error", fe_b, 1);
        checkOutput("b_stop_code", code_b, 2'b10);
        checkOutput("b_stop_data", data_b, 7'h55);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
